// File: rtl/clk_ratio_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : clk_ratio_meter
// Function : Measures high/low/total length of a divided clock in reference
//            cycles, with lock detection and a sticky overflow/no-clock flag.
// Revision : 1.0 - initial release
// ============================================================================
module clk_ratio_meter #(
    parameter int RATIO_WD    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CNT    = 2
) (
    input  logic                I_ref_clk,
    input  logic                I_rst_n,
    input  logic                I_meas_en,
    input  logic                I_div_clk,
    output logic [RATIO_WD-1:0] O_ratio,
    output logic [RATIO_WD-1:0] O_high_cnt,
    output logic [RATIO_WD-1:0] O_low_cnt,
    output logic                O_valid,
    output logic                O_locked,
    output logic                O_err
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ARM  = 3'd1;
    localparam logic [2:0] ST_HIGH = 3'd2;
    localparam logic [2:0] ST_LOW  = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    localparam logic [RATIO_WD:0] MAX_SUM = {1'b0, {RATIO_WD{1'b1}}};
    localparam logic [3:0]        LOCK_TH = 4'(LOCK_CNT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;
    logic                   s;
    logic                   rise;
    logic                   fall;

    logic [2:0]             state;
    logic [2:0]             next_state;
    logic [RATIO_WD-1:0]    hcnt;
    logic [RATIO_WD-1:0]    lcnt;
    logic [RATIO_WD:0]      sum;
    logic                   at_max;
    logic [3:0]             match;
    logic [3:0]             match_nxt;

    logic                   start_high;
    logic                   start_low;
    logic                   inc_h;
    logic                   inc_l;
    logic                   capture;
    logic                   overflow;

    always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], I_div_clk};
            s_d    <= s;
        end
    end

    assign s      = sync_q[SYNC_STAGES-1];
    assign rise   = s & ~s_d;
    assign fall   = ~s & s_d;
    assign sum    = {1'b0, hcnt} + {1'b0, lcnt};
    assign at_max = (sum == MAX_SUM);

    always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (!I_meas_en) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: next_state = ST_ARM;
                ST_ARM:  if (rise) next_state = ST_HIGH;
                ST_HIGH: begin
                    if (fall)        next_state = ST_LOW;
                    else if (at_max) next_state = ST_ERR;
                end
                ST_LOW: begin
                    if (rise)        next_state = ST_HIGH;
                    else if (at_max) next_state = ST_ERR;
                end
                ST_ERR:  if (rise) next_state = ST_HIGH;
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // A rise coinciding with the saturation point completes the period.
    always_comb begin
        start_high = 1'b0;
        start_low  = 1'b0;
        inc_h      = 1'b0;
        inc_l      = 1'b0;
        capture    = 1'b0;
        overflow   = 1'b0;
        if (I_meas_en) begin
            case (state)
                ST_ARM, ST_ERR: start_high = rise;
                ST_HIGH: begin
                    start_low = fall;
                    inc_h     = ~fall & ~at_max;
                    overflow  = ~fall & at_max;
                end
                ST_LOW: begin
                    start_high = rise;
                    capture    = rise;
                    inc_l      = ~rise & ~at_max;
                    overflow   = ~rise & at_max;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        match_nxt = 4'd1;
        if ((match != 4'd0) && (sum[RATIO_WD-1:0] == O_ratio)) begin
            match_nxt = (match >= LOCK_TH) ? match : match + 4'd1;
        end
    end

    always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            hcnt       <= '0;
            lcnt       <= '0;
            match      <= 4'd0;
            O_ratio    <= '0;
            O_high_cnt <= '0;
            O_low_cnt  <= '0;
            O_valid    <= 1'b0;
            O_locked   <= 1'b0;
            O_err      <= 1'b0;
        end else if (!I_meas_en) begin
            hcnt       <= '0;
            lcnt       <= '0;
            match      <= 4'd0;
            O_ratio    <= '0;
            O_high_cnt <= '0;
            O_low_cnt  <= '0;
            O_valid    <= 1'b0;
            O_locked   <= 1'b0;
            O_err      <= 1'b0;
        end else begin
            O_valid <= 1'b0;

            if (start_high)  hcnt <= {{(RATIO_WD-1){1'b0}}, 1'b1};
            else if (inc_h)  hcnt <= hcnt + 1'b1;

            if (start_high)     lcnt <= '0;
            else if (start_low) lcnt <= {{(RATIO_WD-1){1'b0}}, 1'b1};
            else if (inc_l)     lcnt <= lcnt + 1'b1;

            if (capture) begin
                O_ratio    <= sum[RATIO_WD-1:0];
                O_high_cnt <= hcnt;
                O_low_cnt  <= lcnt;
                O_valid    <= 1'b1;
                match      <= match_nxt;
                O_locked   <= (match_nxt >= LOCK_TH);
            end

            if (overflow) begin
                O_err    <= 1'b1;
                O_locked <= 1'b0;
                match    <= 4'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_ratio_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_clk_ratio_meter
// Function : Directed self-checking bench for clk_ratio_meter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_ratio_meter;

    localparam int RATIO_WD = 4;

    logic                clk;
    logic                rst_n;
    logic                meas_en;
    logic                div;
    logic [RATIO_WD-1:0] ratio;
    logic [RATIO_WD-1:0] high_cnt;
    logic [RATIO_WD-1:0] low_cnt;
    logic                valid;
    logic                locked;
    logic                err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int r;
        int h;
        int l;
        int lk;
        int er;
        int cyc;
    } vrec_t;

    vrec_t vlog[$];
    int    rises[$];

    clk_ratio_meter #(
        .RATIO_WD    (RATIO_WD),
        .SYNC_STAGES (2),
        .LOCK_CNT    (2)
    ) dut (
        .I_ref_clk  (clk),
        .I_rst_n    (rst_n),
        .I_meas_en  (meas_en),
        .I_div_clk  (div),
        .O_ratio    (ratio),
        .O_high_cnt (high_cnt),
        .O_low_cnt  (low_cnt),
        .O_valid    (valid),
        .O_locked   (locked),
        .O_err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            vlog.push_back(vrec_t'{int'(ratio), int'(high_cnt), int'(low_cnt),
                                   int'(locked), int'(err), cyc});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {17'd0, ratio, high_cnt, low_cnt, valid, locked, err};
    endfunction

    // Each negedge sets the level sampled by the following posedge.
    task automatic drive(input int h, input int l, input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < h; i++) begin
                @(negedge clk);
                if (div == 1'b0) rises.push_back(cyc + 1);
                div = 1'b1;
            end
            for (int i = 0; i < l; i++) begin
                @(negedge clk);
                div = 1'b0;
            end
        end
    endtask

    // ratio, high, low, locked, err for every expected O_valid in order
    int exp_tab [17][5] = '{
        '{4, 2, 2, 0, 0}, '{4, 2, 2, 1, 0}, '{4, 2, 2, 1, 0}, '{4, 2, 2, 1, 0},
        '{5, 3, 2, 0, 0}, '{5, 3, 2, 1, 0}, '{5, 3, 2, 1, 0}, '{4, 2, 2, 0, 0},
        '{4, 2, 2, 1, 0}, '{6, 3, 3, 0, 0}, '{6, 3, 3, 1, 0}, '{6, 3, 3, 1, 0},
        '{4, 2, 2, 0, 1}, '{15, 14, 1, 0, 0}, '{15, 14, 1, 1, 0},
        '{4, 2, 2, 0, 0}, '{4, 2, 2, 1, 0}
    };

    initial begin
        rst_n   = 1'b0;
        meas_en = 1'b0;
        div     = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", outs(), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outs", outs(), 32'd0);
        meas_en = 1'b1;
        rises.delete();

        drive(2, 2, 4);
        if (vlog.size() > 0 && rises.size() > 1)
            check("valid_latency", 32'(vlog[0].cyc - rises[1]), 32'd2);
        else
            check("valid_latency_missing", 32'(vlog.size()), 32'd1);
        drive(3, 2, 3);
        drive(2, 2, 2);
        drive(3, 3, 3);

        // Hold high: overflow must fire exactly when hcnt reaches 15.
        @(negedge clk);
        rises.push_back(cyc + 1);
        div = 1'b1;
        repeat (17) @(negedge clk);
        check("ovf_err_before", 32'(err), 32'd0);
        @(negedge clk);
        check("ovf_err_set", 32'(err), 32'd1);
        check("ovf_locked", 32'(locked), 32'd0);
        check("ovf_no_valid", 32'(vlog.size()), 32'd12);

        drive(2, 2, 3);
        check("err_sticky", 32'(err), 32'd1);
        @(negedge clk);
        meas_en = 1'b0;
        @(negedge clk);
        check("disable_outs", outs(), 32'd0);
        meas_en = 1'b1;

        drive(14, 1, 2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (div == 1'b0) rises.push_back(cyc + 1);
            div = 1'b1;
        end
        @(negedge clk);
        check("boundary_err", 32'(err), 32'd0);
        check("boundary_ratio", 32'(ratio), 32'd15);

        rst_n = 1'b0;
        #1;
        check("midrun_reset_outs", outs(), 32'd0);
        div = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_no_valid", 32'(vlog.size()), 32'd15);
        drive(2, 2, 3);
        repeat (6) @(negedge clk);

        check("valid_count", 32'(vlog.size()), 32'd17);
        for (int i = 0; i < 17; i++) begin
            if (i < vlog.size()) begin
                check($sformatf("v%0d_ratio", i), 32'(vlog[i].r), 32'(exp_tab[i][0]));
                check($sformatf("v%0d_high", i), 32'(vlog[i].h), 32'(exp_tab[i][1]));
                check($sformatf("v%0d_low", i), 32'(vlog[i].l), 32'(exp_tab[i][2]));
                check($sformatf("v%0d_locked", i), 32'(vlog[i].lk), 32'(exp_tab[i][3]));
                check($sformatf("v%0d_err", i), 32'(vlog[i].er), 32'(exp_tab[i][4]));
            end else begin
                check($sformatf("v%0d_missing", i), 32'(vlog.size()), 32'(i + 1));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
